// File: rtl/hamming_sched_pkg.sv
// Shared constants and state encoding for the Hamming frame scheduler.
package hamming_sched_pkg;
    localparam int WORD_W     = 32;
    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after rr_ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/hamming_frame_scheduler.sv
// Round-robin frame scheduler feeding one Hamming encoder: grabs a 32-bit word per frame,
// shifts it MSB-first for 32 cycles, then idles GAP_CYCLES cycles before the next frame.
module hamming_frame_scheduler
    import hamming_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   word_in,
    output logic [N_REQ-1:0]          grant,
    input  logic                      enc_ready,
    output logic                      enc_data,
    output logic                      enc_valid,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  src_id,
    output logic [CNT_W-1:0]          frame_cnt
);
    localparam int               IDX_W    = $clog2(N_REQ);
    localparam logic [3:0]       GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    sched_state_t       r_state;
    sched_state_t       w_next_state;
    logic [WORD_W-1:0]  r_shift_reg;
    logic [4:0]         r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_src_id;
    logic [N_REQ-1:0]   r_grant;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any_req;
    logic               w_start;
    logic               w_last_bit;
    logic               w_gap_done;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    // Handshake: enc_ready is only a start permission sampled in IDLE; once a frame starts,
    // enc_valid stays high for all 32 bits regardless of enc_ready.
    assign w_start    = (r_state == IDLE) && enable && w_any_req && enc_ready;
    assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == 5'd31);
    assign w_gap_done = (r_state == GAP) && (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        enc_valid    = 1'b0;
        enc_data     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                enc_valid = 1'b1;
                enc_data  = r_shift_reg[WORD_W-1];
                busy      = 1'b1;
                if (w_last_bit) begin
                    w_next_state = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                busy = 1'b1;
                if (w_gap_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_rr_ptr    <= PTR_RST;
            r_src_id    <= '0;
            r_grant     <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_grant <= '0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shift_reg <= word_in[WORD_W*w_winner +: WORD_W];
                        r_src_id    <= w_winner;
                        r_rr_ptr    <= w_winner;
                        r_grant     <= ONE_HOT0 << w_winner;
                        r_bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_shift_reg <= {r_shift_reg[WORD_W-2:0], 1'b0};
                    r_bit_cnt   <= r_bit_cnt + 5'd1;
                    if (w_last_bit) begin
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_gap_cnt   <= '0;
                    end
                end
                GAP: begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign grant     = r_grant;
    assign src_id    = r_src_id;
    assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_hamming_frame_scheduler.sv
// Bench for hamming_frame_scheduler: two instances (default, and CNT_W=2/GAP_CYCLES=0) share stimulus;
// a frame-timeline model checks every cycle, directed tests pin the model with literal values.
module tb_hamming_frame_scheduler;
    logic         clk_in;
    logic         rst;
    logic         enable;
    logic [3:0]   req;
    logic [127:0] word_in;
    logic         enc_ready;

    logic [3:0]   a_grant, b_grant;
    logic         a_enc_data, b_enc_data;
    logic         a_enc_valid, b_enc_valid;
    logic         a_busy, b_busy;
    logic [1:0]   a_src_id, b_src_id;
    logic [15:0]  a_frame_cnt;
    logic [1:0]   b_frame_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int e        = 0;

    hamming_frame_scheduler #(.N_REQ(4), .GAP_CYCLES(2), .CNT_W(16)) u_dut_a (
        .clk_in(clk_in), .rst(rst), .enable(enable), .req(req), .word_in(word_in),
        .grant(a_grant), .enc_ready(enc_ready), .enc_data(a_enc_data),
        .enc_valid(a_enc_valid), .busy(a_busy), .src_id(a_src_id), .frame_cnt(a_frame_cnt)
    );

    hamming_frame_scheduler #(.N_REQ(4), .GAP_CYCLES(0), .CNT_W(2)) u_dut_b (
        .clk_in(clk_in), .rst(rst), .enable(enable), .req(req), .word_in(word_in),
        .grant(b_grant), .enc_ready(enc_ready), .enc_data(b_enc_data),
        .enc_valid(b_enc_valid), .busy(b_busy), .src_id(b_src_id), .frame_cnt(b_frame_cnt)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // model: a frame granted at edge s owns cycles s..s+31 (data), then gap cycles
    typedef struct {
        bit          active;
        int          s;
        int          ptr;
        int          fc;
        int          src;
        logic [31:0] word;
    } mdl_t;

    mdl_t ma, mb;

    task automatic model_step(inout mdl_t m, input int ed, input int gap, input int cnt_w);
        int w;
        int idx;
        if (!rst) begin
            m.active = 0; m.s = 0; m.ptr = 3; m.fc = 0; m.src = 0; m.word = '0;
        end else begin
            if (m.active && ed == m.s + 32) m.fc = (m.fc + 1) % (1 << cnt_w);
            if ((!m.active || ed - 1 > m.s + 31 + gap) && enable && (|req) && enc_ready) begin
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    idx = (m.ptr + k) % 4;
                    if (w < 0 && req[idx]) w = idx;
                end
                m.active = 1; m.s = ed; m.ptr = w; m.src = w;
                m.word = word_in[32*w +: 32];
            end
        end
    endtask

    task automatic model_out(input mdl_t m, input int ed, input int gap,
                             output logic [3:0] g, output logic d, output logic v, output logic b);
        v = m.active && ed >= m.s && ed <= m.s + 31;
        d = v ? m.word[31 - (ed - m.s)] : 1'b0;
        g = (m.active && ed == m.s) ? (4'b0001 << m.src) : 4'b0000;
        b = m.active && ed <= m.s + 31 + gap;
    endtask

    always @(posedge clk_in) begin
        e = e + 1;
        model_step(ma, e, 2, 16);
        model_step(mb, e, 0, 2);
    end

    // scoreboard: every cycle, both instances against the model
    always @(negedge clk_in) begin
        logic [3:0] g;
        logic d, v, b;
        if (e > 0) begin
            model_out(ma, e, 2, g, d, v, b);
            chk("A.grant", a_grant, g);
            chk("A.enc_valid", a_enc_valid, v);
            chk("A.enc_data", a_enc_data, d);
            chk("A.busy", a_busy, b);
            chk("A.src_id", a_src_id, ma.src);
            chk("A.frame_cnt", a_frame_cnt, ma.fc);
            model_out(mb, e, 0, g, d, v, b);
            chk("B.grant", b_grant, g);
            chk("B.enc_valid", b_enc_valid, v);
            chk("B.enc_data", b_enc_data, d);
            chk("B.busy", b_busy, b);
            chk("B.src_id", b_src_id, mb.src);
            chk("B.frame_cnt", b_frame_cnt, mb.fc);
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; req = 4'b0000; enc_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic int oh_idx(input logic [3:0] g);
        int r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        logic [31:0] bits;
        int vcnt;
        int gseen;
        int g_idx[$];
        int g_cyc[$];
        int fc_vals[$];
        int b_cyc[$];
        logic [1:0] prev_fc;

        rst = 1'b0; enable = 1'b0; req = 4'b0000; enc_ready = 1'b1;
        word_in = {32'h0BAD_F00D, 32'h1357_9BDF, 32'hCAFE_0123, 32'hDEAD_BEEF};

        // reset state
        tick();
        tick();
        chk("reset.grant", a_grant, 4'b0000);
        chk("reset.enc_valid", a_enc_valid, 1'b0);
        chk("reset.enc_data", a_enc_data, 1'b0);
        chk("reset.busy", a_busy, 1'b0);
        chk("reset.src_id", a_src_id, 2'd0);
        chk("reset.frame_cnt", a_frame_cnt, 16'd0);
        rst = 1'b1;

        // single word on req0
        req = 4'b0001; enable = 1'b1;
        tick();
        chk("single.grant", a_grant, 4'b0001);
        req = 4'b0000;
        bits = '0; vcnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) tick();
            if (i == 1) chk("single.grant_pulse", a_grant, 4'b0000);
            bits = {bits[30:0], a_enc_data};
            vcnt += int'(a_enc_valid);
        end
        chk("single.bits", bits, 32'hDEAD_BEEF);
        chk("single.valid_cycles", vcnt, 32);
        tick();
        chk("single.valid_after", a_enc_valid, 1'b0);
        chk("single.frame_cnt", a_frame_cnt, 16'd1);
        repeat (5) tick();

        // full load, round-robin order and 35-cycle spacing
        do_reset();
        req = 4'b1111; enable = 1'b1;
        for (int c = 0; c < 200 && g_idx.size() < 5; c++) begin
            tick();
            if (a_grant != 4'b0000) begin
                g_idx.push_back(oh_idx(a_grant));
                g_cyc.push_back(e);
                chk("full.src_id", a_src_id, oh_idx(a_grant));
            end
        end
        chk("full.grants", g_idx.size(), 5);
        if (g_idx.size() == 5) begin
            chk("full.order0", g_idx[0], 0);
            chk("full.order1", g_idx[1], 1);
            chk("full.order2", g_idx[2], 2);
            chk("full.order3", g_idx[3], 3);
            chk("full.order4", g_idx[4], 0);
            for (int i = 1; i < 5; i++) chk("full.spacing", g_cyc[i] - g_cyc[i-1], 35);
        end
        req = 4'b0000; enable = 1'b0;
        repeat (40) tick();

        // back-pressure
        do_reset();
        enc_ready = 1'b0; req = 4'b0100; enable = 1'b1;
        gseen = 0; vcnt = 0;
        repeat (10) begin
            tick();
            gseen += int'(|a_grant);
            vcnt += int'(a_enc_valid);
        end
        chk("bp.no_grant", gseen, 0);
        chk("bp.no_valid", vcnt, 0);
        enc_ready = 1'b1;
        tick();
        chk("bp.grant", a_grant, 4'b0100);
        chk("bp.src_id", a_src_id, 2'd2);
        req = 4'b0000;
        repeat (40) tick();

        // enable drop mid-frame
        do_reset();
        req = 4'b0001; enable = 1'b1;
        tick();
        vcnt = int'(a_enc_valid);
        for (int i = 1; i < 32; i++) begin
            tick();
            vcnt += int'(a_enc_valid);
            if (i == 5) enable = 1'b0;
        end
        tick();
        chk("endrop.valid_cycles", vcnt, 32);
        chk("endrop.valid_after", a_enc_valid, 1'b0);
        chk("endrop.frame_cnt", a_frame_cnt, 16'd1);
        gseen = 0;
        repeat (40) begin
            tick();
            gseen += int'(|a_grant);
        end
        chk("endrop.no_grant", gseen, 0);
        enable = 1'b1;
        tick();
        chk("endrop.regrant", a_grant, 4'b0001);
        req = 4'b0000; enable = 1'b0;
        repeat (40) tick();
        chk("endrop.frame_cnt2", a_frame_cnt, 16'd2);

        // reset mid-frame (no reset beforehand, so frame_cnt starts non-zero)
        req = 4'b0001; enable = 1'b1;
        tick();
        repeat (10) tick();
        chk("rstmid.valid_before", a_enc_valid, 1'b1);
        rst = 1'b0;
        tick();
        chk("rstmid.valid", a_enc_valid, 1'b0);
        chk("rstmid.busy", a_busy, 1'b0);
        chk("rstmid.frame_cnt", a_frame_cnt, 16'd0);
        rst = 1'b1; req = 4'b1001;
        tick();
        chk("rstmid.grant", a_grant, 4'b0001);
        req = 4'b0000;
        repeat (40) tick();

        // counter wrap and zero gap on instance B
        do_reset();
        req = 4'b1111; enable = 1'b1;
        prev_fc = 2'd0;
        for (int c = 0; c < 250 && fc_vals.size() < 5; c++) begin
            tick();
            if (b_grant != 4'b0000) b_cyc.push_back(e);
            if (b_frame_cnt != prev_fc) begin
                fc_vals.push_back(int'(b_frame_cnt));
                prev_fc = b_frame_cnt;
            end
        end
        chk("wrap.changes", fc_vals.size(), 5);
        if (fc_vals.size() == 5) begin
            chk("wrap.fc0", fc_vals[0], 1);
            chk("wrap.fc1", fc_vals[1], 2);
            chk("wrap.fc2", fc_vals[2], 3);
            chk("wrap.fc3", fc_vals[3], 0);
            chk("wrap.fc4", fc_vals[4], 1);
        end
        chk("wrap.grants", b_cyc.size() >= 5, 1);
        for (int i = 1; i < b_cyc.size(); i++) chk("wrap.spacing", b_cyc[i] - b_cyc[i-1], 33);
        req = 4'b0000; enable = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
